// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IF     = 2'd1,
    OWN_DM_RD  = 2'd2,
    OWN_DM_ERR = 2'd3
  } owner_e;

  localparam int unsigned WORD_OFF_W    = 2;
  localparam logic [WORD_OFF_W-1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants while fetch waits; flags when fetch must win.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic starve
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (dm_gnt) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = if_req && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-ported memory between fetch and load/store.
// Optional fetch starvation guard: MEM_PORT_ARBITER_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_req,
  input  logic [ADDR_W-1:0]            if_addr,
  output logic                         if_gnt,
  output logic                         if_rvalid,
  output logic [DATA_W-1:0]            if_rdata,
  input  logic                         dm_req,
  input  logic                         dm_we,
  input  logic [ADDR_W-1:0]            dm_addr,
  input  logic [DATA_W-1:0]            dm_wdata,
  output logic                         dm_gnt,
  output logic                         dm_rvalid,
  output logic [DATA_W-1:0]            dm_rdata,
  output logic                         dm_err,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-WORD_OFF_W-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  owner_e owner_q;
  owner_e owner_d;
  logic   starve_hit;
  logic   dm_misalign;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (if_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt),
    .starve (starve_hit)
  );

  logic unused_if_off;
  assign unused_if_off = ^if_addr[WORD_OFF_W-1:0];
`else
  assign starve_hit = 1'b0;

  logic unused_if_off;
  assign unused_if_off = ^if_addr[WORD_OFF_W-1:0] ^ (STARVE_LIMIT == 0);
`endif

  assign dm_misalign = |(dm_addr[WORD_OFF_W-1:0] & MISALIGN_MASK);

  // Data wins unless the starvation guard forces a fetch slot.
  assign dm_gnt = dm_req && !starve_hit;
  assign if_gnt = if_req && !dm_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (dm_gnt) begin
      mem_en    = !dm_misalign;
      mem_we    = dm_we && !dm_misalign;
      mem_addr  = dm_addr[ADDR_W-1:WORD_OFF_W];
      mem_wdata = dm_wdata;
      if (dm_misalign) begin
        owner_d = OWN_DM_ERR;
      end else if (!dm_we) begin
        owner_d = OWN_DM_RD;
      end
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_W-1:WORD_OFF_W];
      owner_d  = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Response stage: the owner tag steers the shared read bus to one requester.
  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    dm_rvalid = (owner_q == OWN_DM_RD) || (owner_q == OWN_DM_ERR);
    dm_err    = (owner_q == OWN_DM_ERR);
    if_rdata  = (owner_q == OWN_IF)    ? mem_rdata : '0;
    dm_rdata  = (owner_q == OWN_DM_RD) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid: got %b expected 0", if_rvalid); end
    checks++; if (dm_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dm_rvalid: got %b expected 0", dm_rvalid); end
    checks++; if (dm_err !== 1'b0) begin errors++; $display("FAIL reset_dm_err: got %b expected 0", dm_err); end
    checks++; if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b0000) begin errors++; $display("FAIL reset_comb: got %b expected 0000", {if_gnt, dm_gnt, mem_en, mem_we}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    checks++; if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010) begin errors++; $display("FAIL fetch_gnt: got %b expected 1010", {if_gnt, dm_gnt, mem_en, mem_we}); end
    checks++; if (mem_addr !== 30'd4) begin errors++; $display("FAIL fetch_addr: got %h expected 4", mem_addr); end
    step();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid: got if=%b dm=%b expected if=1 dm=0", if_rvalid, dm_rvalid); end
    checks++; if (if_rdata !== 32'hA500_0004) begin errors++; $display("FAIL fetch_rdata: got %h expected a5000004", if_rdata); end
    // Low address bits are ignored for fetch.
    if_req = 1'b1; if_addr = 32'h0000_001B;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 30'd6) begin errors++; $display("FAIL fetch_unaligned: got en=%b addr=%h expected en=1 addr=6", mem_en, mem_addr); end
    step();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA500_0006) begin errors++; $display("FAIL fetch_unaligned_rdata: got v=%b d=%h expected v=1 d=a5000006", if_rvalid, if_rdata); end
    step();
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL fetch_idle: got v=%b d=%h expected v=0 d=0", if_rvalid, if_rdata); end
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    @(negedge clk);
    checks++; if ({if_gnt, dm_gnt} !== 2'b01) begin errors++; $display("FAIL coll_gnt: got if=%b dm=%b expected if=0 dm=1", if_gnt, dm_gnt); end
    checks++; if (mem_addr !== 30'd8 || mem_en !== 1'b1) begin errors++; $display("FAIL coll_addr: got en=%b addr=%h expected en=1 addr=8", mem_en, mem_addr); end
    step();
    dm_req = 1'b0;
    checks++; if (dm_rvalid !== 1'b1 || dm_err !== 1'b0 || dm_rdata !== 32'hA500_0008) begin errors++; $display("FAIL coll_dm_resp: got v=%b e=%b d=%h expected v=1 e=0 d=a5000008", dm_rvalid, dm_err, dm_rdata); end
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL coll_if_quiet: got v=%b d=%h expected v=0 d=0", if_rvalid, if_rdata); end
    @(negedge clk);
    checks++; if ({if_gnt, dm_gnt} !== 2'b10 || mem_addr !== 30'd0) begin errors++; $display("FAIL coll_if_gnt: got if=%b dm=%b addr=%h expected if=1 dm=0 addr=0", if_gnt, dm_gnt, mem_addr); end
    step();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA500_0000 || dm_rvalid !== 1'b0) begin errors++; $display("FAIL coll_if_resp: got v=%b d=%h dmv=%b expected v=1 d=a5000000 dmv=0", if_rvalid, if_rdata, dm_rvalid); end
  endtask

  task automatic test_write_read();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({dm_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 30'd16 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_issue: got g/en/we=%b addr=%h wd=%h expected 111 addr=10 wd=deadbeef", {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata); end
    step();
    dm_we = 1'b0; dm_wdata = '0;
    checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_resp: got dm=%b if=%b expected 0 0", dm_rvalid, if_rvalid); end
    @(negedge clk);
    checks++; if ({dm_gnt, mem_en, mem_we} !== 3'b110 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rd_issue: got g/en/we=%b wd=%h expected 110 wd=0", {dm_gnt, mem_en, mem_we}, mem_wdata); end
    step();
    dm_req = 1'b0;
    checks++; if (dm_rvalid !== 1'b1 || dm_err !== 1'b0 || dm_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr: got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", dm_rvalid, dm_err, dm_rdata); end
  endtask

  task automatic test_misalign();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h42;
    @(negedge clk);
    checks++; if (dm_gnt !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL mis_rd_issue: got g=%b en=%b expected g=1 en=0", dm_gnt, mem_en); end
    step();
    dm_we = 1'b1; dm_addr = 32'h41; dm_wdata = 32'h1234_5678;
    checks++; if (dm_rvalid !== 1'b1 || dm_err !== 1'b1 || dm_rdata !== 32'h0) begin errors++; $display("FAIL mis_rd_resp: got v=%b e=%b d=%h expected v=1 e=1 d=0", dm_rvalid, dm_err, dm_rdata); end
    @(negedge clk);
    checks++; if (dm_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_wr_issue: got g=%b en=%b we=%b expected 1 0 0", dm_gnt, mem_en, mem_we); end
    step();
    dm_req = 1'b0; dm_we = 1'b0;
    checks++; if (dm_rvalid !== 1'b1 || dm_err !== 1'b1 || dm_rdata !== 32'h0) begin errors++; $display("FAIL mis_wr_resp: got v=%b e=%b d=%h expected v=1 e=1 d=0", dm_rvalid, dm_err, dm_rdata); end
    step();
    checks++; if (dm_rvalid !== 1'b0 || dm_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got v=%b e=%b expected 0 0", dm_rvalid, dm_err); end
    checks++; if (mem[16] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mis_no_write: got %h expected deadbeef", mem[16]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    if_req = 1'b1; if_addr = 32'h0;
    step();
    for (int k = 1; k < 5; k++) begin
      if_addr = 32'(k * 4);
      exp_d = 32'hA500_0000 | 32'(k - 1);
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp_d) begin errors++; $display("FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", k, if_rvalid, if_rdata, exp_d); end
      step();
    end
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA500_0004) begin errors++; $display("FAIL b2b_last: got v=%b d=%h expected v=1 d=a5000004", if_rvalid, if_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h10;
    step();
    if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_drop: got v=%b d=%h expected v=0 d=0", if_rvalid, if_rdata); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet_%0d: got if=%b dm=%b expected 0 0", k, if_rvalid, dm_rvalid); end
    end
  endtask

  task automatic test_starve();
    logic exp_if;
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
      exp_if = ((k % 5) == 4);
`else
      exp_if = 1'b0;
`endif
      checks++; if (if_gnt !== exp_if || dm_gnt !== !exp_if) begin errors++; $display("FAIL starve_%0d: got if=%b dm=%b expected if=%b dm=%b", k, if_gnt, dm_gnt, exp_if, !exp_if); end
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_write_read();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_starve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, word-organised memory between two requesters: the fetch unit (instruction reads) and the load/store path (data reads and writes).
- Sits between the core datapath and a unified memory macro; lets instruction and data memory collapse into one array.
- Handshake is req/gnt per access, then a response strobe one cycle later.
- Pipelined: one memory access issued per cycle, with a registered response-owner tag routing read data.

Parameters:
- ADDR_W, 32, byte-address width from both requesters.
- DATA_W, 32, word width.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits; used only with the optional feature.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid; exactly one cycle after if_gnt.
- if_rdata  out  DATA_W  instruction word.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  response for an accepted read, or for any misaligned access.
- dm_rdata  out  DATA_W  load data; 0 when dm_err.
- dm_err  out  1  qualifies dm_rvalid: the access was misaligned.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  word index, taken from addr[ADDR_W-1:2].
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Reset (async, rst_n=0):
  - owner register = NONE; starvation counter = 0.
  - Registered outputs if_rvalid, dm_rvalid and dm_err go to 0.
  - Combinational outputs are 0 whenever both req inputs are 0.
  - Any response in flight is dropped; no rvalid is produced after reset releases.
- Grant logic (combinational, same cycle as req):
  - Fixed priority: dm_req wins over if_req.
  - Exactly one of if_gnt and dm_gnt is high, or neither.
  - The arbiter never stalls a request for any other reason: a request is granted as soon as it wins priority.
- Issue: the granted request drives mem_en=1, mem_addr=addr[ADDR_W-1:2], mem_we=dm_we (0 for fetch), and mem_wdata=dm_wdata (0 for fetch).
- Alignment: addr[1:0] is ignored for fetch. A data access with addr[1:0]!=0 is still granted, but:
  - mem_en is 0 that cycle;
  - the next cycle gives dm_rvalid=1, dm_err=1 and dm_rdata=0, for reads and writes alike.
- Owner register (next state after a grant):
  - IF when the granted access is a fetch;
  - DM_RD when it is an aligned data read;
  - DM_ERR when it is a misaligned data access;
  - NONE for aligned writes and for cycles with no grant.
- Response stage (driven from the owner register, one cycle after grant):
  - IF: if_rvalid=1 and if_rdata=mem_rdata.
  - DM_RD: dm_rvalid=1 and dm_rdata=mem_rdata.
  - Otherwise the rdata outputs are 0.
- Aligned writes complete at dm_gnt and produce no rvalid.
- Back-to-back: a new grant in cycle N+1 overlaps the response for cycle N. Full throughput is 1 access per cycle.
- Simultaneous requests: dm is granted and if_req stays pending. Fetch is granted in the first cycle where dm_req=0.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STARVE_GUARD_EN.
- With the macro defined:
  - A counter of up to $clog2(STARVE_LIMIT+1) bits increments on each dm_gnt while if_req=1.
  - The counter clears on if_gnt, and whenever if_req=0.
  - When the count equals STARVE_LIMIT and if_req=1, fetch is granted instead of data; the counter then clears.
- Without the macro: no counter exists, and the fixed dm priority can starve fetch indefinitely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - enum owner_e {OWN_NONE, OWN_IF, OWN_DM_RD, OWN_DM_ERR};
  - localparams for the word-offset width (2) and the misalignment mask.
- One natural sub-module, mem_arb_starve_ctr: the starvation counter, instantiated only under the macro.
- Everything else stays in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010 -> same cycle if_gnt=1, mem_en=1, mem_addr=0x4. Next cycle if_rvalid=1 with if_rdata equal to the memory word at index 4.
- Collision: if_req=1 and dm_req=1 (read, 0x20) in the same cycle -> dm_gnt=1, if_gnt=0. Next cycle dm_rvalid=1 and fetch is granted, provided dm_req has dropped.
- Write then read the same word: dm write 0xDEAD_BEEF to 0x40, then dm read 0x40 -> no rvalid for the write; the read returns 0xDEAD_BEEF with dm_err=0.
- Misaligned data read of 0x42 -> mem_en=0. Next cycle dm_rvalid=1, dm_err=1, dm_rdata=0.
- Reset mid-operation: assert rst_n=0 one cycle after if_gnt -> if_rvalid=0 immediately, and no response appears after release.
- With the macro and STARVE_LIMIT=4: hold dm_req=1 and if_req=1 continuously -> 4 dm grants, 1 if grant, then the pattern repeats. Without the macro, fetch is never granted.
